// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: address map, mstatus bit positions, read mux helpers.
package csr_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef struct packed {
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] mcycleh;
  } csr_regs_t;

  function automatic logic csr_writable(input logic [CSR_AW-1:0] a);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH: csr_writable = 1'b1;
      default:                                       csr_writable = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] csr_read(input csr_regs_t r,
                                               input logic [CSR_AW-1:0] a,
                                               input logic [XLEN-1:0] misa);
    case (a)
      CSR_MSTATUS:  csr_read = r.mstatus;
      CSR_MISA:     csr_read = misa;
      CSR_MIE:      csr_read = r.mie;
      CSR_MTVEC:    csr_read = r.mtvec;
      CSR_MSCRATCH: csr_read = r.mscratch;
      CSR_MEPC:     csr_read = r.mepc;
      CSR_MCAUSE:   csr_read = r.mcause;
      CSR_MCYCLE:   csr_read = r.mcycle;
      CSR_MCYCLEH:  csr_read = r.mcycleh;
      default:      csr_read = '0;
    endcase
  endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter; a write to either half loads it and freezes both halves that cycle.
module csr_cycle_counter
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            lo_we,
  input  logic            hi_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] cycle_lo,
  output logic [XLEN-1:0] cycle_hi
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_lo <= '0;
      cycle_hi <= '0;
    end else if (lo_we || hi_we) begin
      if (lo_we) cycle_lo <= wdata;
      if (hi_we) cycle_hi <= wdata;
    end else begin
      {cycle_hi, cycle_lo} <= {cycle_hi, cycle_lo} + 64'(1);
    end
  end

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR file shared by the execute stage and the interrupt controller,
// with controller-priority write arbitration and write-to-read bypass on both read ports.
module csr_reg_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL = 32'h40000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] data_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] data_o,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_data_i,
  input  logic [31:0] clint_raddr_i,
  output logic [31:0] clint_data_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic        global_interrupt_en_o
);

  logic [XLEN-1:0]   mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0]   mcycle, mcycleh;
  logic              wr_en;
  logic [CSR_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   wr_val;
  csr_regs_t         regs;

  // Upper address bits are ignored by the decoder.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i[31:12], raddr_i[31:12],
                              clint_waddr_i[31:12], clint_raddr_i[31:12]};

  // Controller write wins outright; the execute write is dropped.
  always_comb begin
    wr_en   = we_i | clint_we_i;
    wr_addr = waddr_i[CSR_AW-1:0];
    wr_data = data_i;
    if (clint_we_i) begin
      wr_addr = clint_waddr_i[CSR_AW-1:0];
      wr_data = clint_data_i;
    end
    wr_val = (wr_addr == CSR_MEPC) ? {wr_data[XLEN-1:2], 2'b00} : wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS:  mstatus_q  <= wr_val;
        CSR_MIE:      mie_q      <= wr_val;
        CSR_MTVEC:    mtvec_q    <= wr_val;
        CSR_MSCRATCH: mscratch_q <= wr_val;
        CSR_MEPC:     mepc_q     <= wr_val;
        CSR_MCAUSE:   mcause_q   <= wr_val;
        default:      ;
      endcase
    end
  end

  csr_cycle_counter u_cycle (
    .clk      (clk),
    .rst      (rst),
    .lo_we    (wr_en && (wr_addr == CSR_MCYCLE)),
    .hi_we    (wr_en && (wr_addr == CSR_MCYCLEH)),
    .wdata    (wr_data),
    .cycle_lo (mcycle),
    .cycle_hi (mcycleh)
  );

  always_comb begin
    regs = '{mstatus: mstatus_q, mie: mie_q, mtvec: mtvec_q, mscratch: mscratch_q,
             mepc: mepc_q, mcause: mcause_q, mcycle: mcycle, mcycleh: mcycleh};
  end

  // Read ports: a committed write to a writable CSR is forwarded in the same cycle.
  always_comb begin
    data_o = csr_read(regs, raddr_i[CSR_AW-1:0], MISA_VAL);
    if (wr_en && csr_writable(wr_addr) && (wr_addr == raddr_i[CSR_AW-1:0]))
      data_o = wr_val;
    clint_data_o = csr_read(regs, clint_raddr_i[CSR_AW-1:0], MISA_VAL);
    if (wr_en && csr_writable(wr_addr) && (wr_addr == clint_raddr_i[CSR_AW-1:0]))
      clint_data_o = wr_val;
  end

  assign csr_mtvec_o           = mtvec_q;
  assign csr_mepc_o            = mepc_q;
  assign csr_mstatus_o         = mstatus_q;
  assign global_interrupt_en_o = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_reg_file.sv
// Directed bench for csr_reg_file: reset, bypass, trap/MRET sequencing, arbitration, counter wrap.
module tb_csr_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] waddr_i, data_i, raddr_i, data_o;
  logic        clint_we_i;
  logic [31:0] clint_waddr_i, clint_data_i, clint_raddr_i, clint_data_o;
  logic [31:0] csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
  logic        global_interrupt_en_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_reg_file #(.MISA_VAL(32'h40000100)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .we_i                  (we_i),
    .waddr_i               (waddr_i),
    .data_i                (data_i),
    .raddr_i               (raddr_i),
    .data_o                (data_o),
    .clint_we_i            (clint_we_i),
    .clint_waddr_i         (clint_waddr_i),
    .clint_data_i          (clint_data_i),
    .clint_raddr_i         (clint_raddr_i),
    .clint_data_o          (clint_data_o),
    .csr_mtvec_o           (csr_mtvec_o),
    .csr_mepc_o            (csr_mepc_o),
    .csr_mstatus_o         (csr_mstatus_o),
    .global_interrupt_en_o (global_interrupt_en_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0;
    clint_we_i = 1'b0; clint_waddr_i = '0; clint_data_i = '0; clint_raddr_i = '0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    raddr_i = 32'h301; clint_raddr_i = 32'hB00;
    #1;
    check("rst_mtvec", csr_mtvec_o, 32'h0);
    check("rst_mepc", csr_mepc_o, 32'h0);
    check("rst_mstatus", csr_mstatus_o, 32'h0);
    check("rst_gie", 32'(global_interrupt_en_o), 32'h0);
    check("rst_misa", data_o, 32'h40000100);
    check("rst_mcycle", clint_data_o, 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mcycle_after_10", clint_data_o, 32'd10);
    check("exports_idle_mstatus", csr_mstatus_o, 32'h0);

    // Execute write to mtvec, same-cycle bypass then export
    @(negedge clk);
    we_i = 1'b1; waddr_i = 32'h305; data_i = 32'h100; raddr_i = 32'h305;
    #1;
    check("mtvec_bypass", data_o, 32'h100);
    check("mtvec_export_pre", csr_mtvec_o, 32'h0);
    @(negedge clk);
    we_i = 1'b0;
    #1;
    check("mtvec_export", csr_mtvec_o, 32'h100);
    check("mtvec_stored_read", data_o, 32'h100);

    // Enable interrupts
    @(negedge clk);
    we_i = 1'b1; waddr_i = 32'h300; data_i = 32'h8;
    @(negedge clk);
    we_i = 1'b0;
    #1;
    check("gie_enabled", 32'(global_interrupt_en_o), 32'h1);

    // Trap entry: mepc, mstatus (MPIE=1, MIE=0), mcause on consecutive cycles
    @(negedge clk);
    clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h80000006;
    clint_raddr_i = 32'h341;
    #1;
    check("mepc_bypass_masked", clint_data_o, 32'h80000004);
    @(negedge clk);
    clint_waddr_i = 32'h300; clint_data_i = 32'h80;
    #1;
    check("trap_mepc_export", csr_mepc_o, 32'h80000004);
    check("trap_gie_still_1", 32'(global_interrupt_en_o), 32'h1);
    @(negedge clk);
    clint_waddr_i = 32'h342; clint_data_i = 32'h8000000B;
    #1;
    check("trap_gie_fell", 32'(global_interrupt_en_o), 32'h0);
    check("trap_mstatus_export", csr_mstatus_o, 32'h80);
    @(negedge clk);
    clint_we_i = 1'b0; clint_raddr_i = 32'h342;
    #1;
    check("trap_mcause", clint_data_o, 32'h8000000B);

    // MRET
    @(negedge clk);
    clint_we_i = 1'b1; clint_waddr_i = 32'h300; clint_data_i = 32'h88;
    #1;
    check("mret_gie_pre", 32'(global_interrupt_en_o), 32'h0);
    @(negedge clk);
    clint_we_i = 1'b0;
    #1;
    check("mret_gie_rose", 32'(global_interrupt_en_o), 32'h1);
    check("mret_mstatus", csr_mstatus_o, 32'h88);

    // Simultaneous writes: controller wins, execute dropped
    @(negedge clk);
    clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h40; clint_raddr_i = 32'h341;
    we_i = 1'b1; waddr_i = 32'h340; data_i = 32'h55; raddr_i = 32'h340;
    #1;
    check("arb_no_exec_bypass", data_o, 32'h0);
    check("arb_clint_bypass", clint_data_o, 32'h40);
    @(negedge clk);
    clint_we_i = 1'b0; we_i = 1'b0;
    #1;
    check("arb_mepc", csr_mepc_o, 32'h40);
    check("arb_mscratch", data_o, 32'h0);

    // Counter carry: load hi=0, then lo=FFFFFFFF, then let it wrap
    @(negedge clk);
    we_i = 1'b1; waddr_i = 32'hB80; data_i = 32'h0;
    @(negedge clk);
    waddr_i = 32'hB00; data_i = 32'hFFFFFFFF; raddr_i = 32'hB00;
    #1;
    check("mcycle_bypass", data_o, 32'hFFFFFFFF);
    @(negedge clk);
    we_i = 1'b0; clint_raddr_i = 32'hB80;
    #1;
    check("mcycle_loaded", data_o, 32'hFFFFFFFF);
    check("mcycleh_loaded", clint_data_o, 32'h0);
    @(negedge clk);
    #1;
    check("mcycle_wrap", data_o, 32'h0);
    check("mcycleh_carry", clint_data_o, 32'h1);

    // Read-only and unmapped writes are ignored
    @(negedge clk);
    we_i = 1'b1; waddr_i = 32'hF14; data_i = 32'h1234; raddr_i = 32'hF14;
    #1;
    check("mhartid_no_bypass", data_o, 32'h0);
    @(negedge clk);
    waddr_i = 32'h7C0; data_i = 32'h1; raddr_i = 32'h7C0;
    #1;
    check("unmapped_no_bypass", data_o, 32'h0);
    @(negedge clk);
    we_i = 1'b0; raddr_i = 32'hF14; clint_raddr_i = 32'h7C0;
    #1;
    check("mhartid_read", data_o, 32'h0);
    check("unmapped_read", clint_data_o, 32'h0);
    check("ro_mtvec_kept", csr_mtvec_o, 32'h100);
    check("ro_mepc_kept", csr_mepc_o, 32'h40);
    check("ro_mstatus_kept", csr_mstatus_o, 32'h88);
    raddr_i = 32'h0001_0305; clint_raddr_i = 32'h340;
    #1;
    check("addr_alias_mtvec", data_o, 32'h100);
    check("ro_mscratch_kept", clint_data_o, 32'h0);

    // Reset beats a concurrent write
    @(negedge clk);
    rst = 1'b1; clint_we_i = 1'b1; clint_waddr_i = 32'h305; clint_data_i = 32'hABC;
    @(negedge clk);
    rst = 1'b0; clint_we_i = 1'b0; clint_raddr_i = 32'hB00;
    #1;
    check("rst_wins_mtvec", csr_mtvec_o, 32'h0);
    check("rst_wins_mstatus", csr_mstatus_o, 32'h0);
    check("rst_wins_gie", 32'(global_interrupt_en_o), 32'h0);
    check("rst_wins_mcycle", clint_data_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
